// File: rtl/wb_daq_slave_regs.sv
// -----------------------------------------------------------------------------
// wb_daq_slave_regs
//
// Wishbone B3 classic slave register file for the DAQ subsystem. It holds the
// global DAQ control word plus four per-channel DMA address registers and four
// per-channel control registers. These drive the DAQ datapath as static outputs.
// It also returns four live, read-only channel status words and raises a
// registered level interrupt.
//
// Register map (byte offsets, wb_adr_i[1:0] ignored):
//   0x00            DAQ_CONTROL          RW
//   0x04..0x10      CH0..CH3 ADDRESS     RW
//   0x14..0x20      CH0..CH3 CONTROL     RW
//   0x24..0x30      CH0..CH3 STATUS      RO (live input)
//   other           unmapped, reads 0
//
// Optional build macro: WB_DAQ_SLAVE_ERR_EN
//   When defined, two kinds of cycle complete with a wb_err_o pulse instead of
//   an ack, and leave all registers unchanged:
//     - accesses to unmapped offsets
//     - writes to STATUS offsets
//   When undefined, wb_err_o is tied 0 and those cycles are acked.
//
// Ports:
//   wb_clk, wb_rst            bus clock, asynchronous active-low reset
//   wb_adr_i .. wb_bte_i      Wishbone slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o        Wishbone slave outputs (rty tied 0)
//   daq_control_reg           global control word
//   daq_channelN_address_reg  channel N DMA address (N = 0..3)
//   daq_channelN_control_reg  channel N control     (N = 0..3)
//   daq_channelN_status_reg   channel N status input (N = 0..3)
//   interrupt                 DAQ_CONTROL[0] & |(CHk_CONTROL[1] & CHk_STATUS[0])
// -----------------------------------------------------------------------------
module wb_daq_slave_regs #(
    parameter int dw = 32,
    parameter int aw = 8
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [31:0]   daq_control_reg,
    output logic [31:0]   daq_channel0_address_reg,
    output logic [31:0]   daq_channel1_address_reg,
    output logic [31:0]   daq_channel2_address_reg,
    output logic [31:0]   daq_channel3_address_reg,
    output logic [31:0]   daq_channel0_control_reg,
    output logic [31:0]   daq_channel1_control_reg,
    output logic [31:0]   daq_channel2_control_reg,
    output logic [31:0]   daq_channel3_control_reg,
    input  logic [31:0]   daq_channel0_status_reg,
    input  logic [31:0]   daq_channel1_status_reg,
    input  logic [31:0]   daq_channel2_status_reg,
    input  logic [31:0]   daq_channel3_status_reg,
    output logic          interrupt
);

    // Word indices into the map. RW registers occupy 0..8, STATUS 9..12.
    localparam int NUM_RW     = 9;
    localparam int STATUS_LO  = 9;
    localparam int STATUS_HI  = 12;

    // rw_regs[0] = DAQ_CONTROL, [1..4] = CHk ADDRESS, [5..8] = CHk CONTROL
    logic [31:0]   rw_regs [NUM_RW];
    logic [31:0]   status  [4];

    logic [aw-3:0] word_idx;
    logic          request;
    logic          is_rw;
    logic          access_fault;
    logic [31:0]   read_data;
    logic          irq_next;

    // Cycle-type, burst-type and byte-offset bits carry no meaning here.
    logic          unused_inputs;
    assign unused_inputs = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign status[0] = daq_channel0_status_reg;
    assign status[1] = daq_channel1_status_reg;
    assign status[2] = daq_channel2_status_reg;
    assign status[3] = daq_channel3_status_reg;

    assign word_idx = wb_adr_i[aw-1:2];

    // A new request is only taken while no response is on the bus, so a held
    // strobe is answered every second cycle.
    assign request = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

    // NOTE: every signal written in always_comb gets a default at the top, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        read_data = '0;
        is_rw     = 1'b0;
        if (int'(word_idx) < NUM_RW) begin
            is_rw     = 1'b1;
            read_data = rw_regs[int'(word_idx)];
        end else if (int'(word_idx) <= STATUS_HI) begin
            read_data = status[int'(word_idx) - STATUS_LO];
        end
    end

`ifdef WB_DAQ_SLAVE_ERR_EN
    // Fault: an unmapped offset, or a write to a STATUS offset.
    assign access_fault = (int'(word_idx) > STATUS_HI) | (wb_we_i & ~is_rw);
`else
    assign access_fault = 1'b0;
`endif

    always_comb begin
        irq_next = 1'b0;
        for (int k = 0; k < 4; k++) begin
            irq_next = irq_next | (rw_regs[5 + k][1] & status[k][0]);
        end
        irq_next = irq_next & rw_regs[0][0];
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            interrupt <= 1'b0;
            // NOTE: this register array is reset element by element. It is a
            // small set of flops with defined reset values, not a RAM.
            for (int i = 0; i < NUM_RW; i++) begin
                rw_regs[i] <= '0;
            end
        end else begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            interrupt <= irq_next;
            if (request) begin
                if (access_fault) begin
                    wb_err_o <= 1'b1;
                end else begin
                    wb_ack_o <= 1'b1;
                    wb_dat_o <= read_data;
                    if (wb_we_i && is_rw) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wb_sel_i[b]) begin
                                rw_regs[int'(word_idx)][8*b +: 8] <= wb_dat_i[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign wb_rty_o = 1'b0;

    assign daq_control_reg          = rw_regs[0];
    assign daq_channel0_address_reg = rw_regs[1];
    assign daq_channel1_address_reg = rw_regs[2];
    assign daq_channel2_address_reg = rw_regs[3];
    assign daq_channel3_address_reg = rw_regs[4];
    assign daq_channel0_control_reg = rw_regs[5];
    assign daq_channel1_control_reg = rw_regs[6];
    assign daq_channel2_control_reg = rw_regs[7];
    assign daq_channel3_control_reg = rw_regs[8];

endmodule

// File: tb/tb_wb_daq_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_wb_daq_slave_regs
//
// Self-checking bench for wb_daq_slave_regs. A register-map model written from
// the bus behaviour (named registers, byte-lane merge, interrupt equation)
// predicts every response. Directed steps cover reset state, lane writes,
// status reads, interrupt, unmapped access, held strobe and mid-cycle reset.
// A randomized phase follows. Honour WB_DAQ_SLAVE_ERR_EN when defined.
// -----------------------------------------------------------------------------
module tb_wb_daq_slave_regs;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic [7:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o, interrupt;
    logic [31:0] ctl_o;
    logic [31:0] addr_o [4];
    logic [31:0] chc_o  [4];
    logic [31:0] st     [4];

    int checks   = 0;
    int failures = 0;

    // Reference model of the register map
    logic [31:0] m_ctl;
    logic [31:0] m_addr [4];
    logic [31:0] m_chc  [4];

    always #5 wb_clk = ~wb_clk;

    wb_daq_slave_regs dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o),
        .daq_control_reg(ctl_o),
        .daq_channel0_address_reg(addr_o[0]), .daq_channel1_address_reg(addr_o[1]),
        .daq_channel2_address_reg(addr_o[2]), .daq_channel3_address_reg(addr_o[3]),
        .daq_channel0_control_reg(chc_o[0]),  .daq_channel1_control_reg(chc_o[1]),
        .daq_channel2_control_reg(chc_o[2]),  .daq_channel3_control_reg(chc_o[3]),
        .daq_channel0_status_reg(st[0]), .daq_channel1_status_reg(st[1]),
        .daq_channel2_status_reg(st[2]), .daq_channel3_status_reg(st[3]),
        .interrupt(interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic exp_irq();
        logic any = 1'b0;
        for (int k = 0; k < 4; k++) any = any | (m_chc[k][1] & st[k][0]);
        return m_ctl[0] & any;
    endfunction

    task automatic model_reset();
        m_ctl = '0;
        for (int k = 0; k < 4; k++) begin m_addr[k] = '0; m_chc[k] = '0; end
    endtask

    // Predict the response of one access and apply its side effects to the model.
    task automatic model_access(input logic [7:0] a, input logic we, input logic [31:0] d,
                                input logic [3:0] sel, output logic e_ack,
                                output logic e_err, output logic [31:0] e_dat);
        int  off = int'(a) & 'hFC;
        logic mapped = (off <= 'h30);
        logic is_st  = (off >= 'h24) && (off <= 'h30);
        logic fault  = 1'b0;
`ifdef WB_DAQ_SLAVE_ERR_EN
        fault = !mapped || (we && is_st);
`endif
        e_ack = !fault;
        e_err = fault;
        e_dat = '0;
        if (fault) return;
        if (off == 'h00)                    e_dat = m_ctl;
        else if (off >= 'h04 && off <= 'h10) e_dat = m_addr[(off - 'h04) / 4];
        else if (off >= 'h14 && off <= 'h20) e_dat = m_chc[(off - 'h14) / 4];
        else if (is_st)                      e_dat = st[(off - 'h24) / 4];
        if (we) begin
            if (off == 'h00)                     m_ctl = merge(m_ctl, d, sel);
            else if (off >= 'h04 && off <= 'h10) m_addr[(off - 'h04) / 4] = merge(m_addr[(off - 'h04) / 4], d, sel);
            else if (off >= 'h14 && off <= 'h20) m_chc[(off - 'h14) / 4] = merge(m_chc[(off - 'h14) / 4], d, sel);
        end
    endtask

    // One classic single cycle: request set up at negedge, response sampled
    // 1 ns after the next rising edge, bus released at the following negedge.
    task automatic bus(input string tag, input logic [7:0] a, input logic we,
                       input logic [31:0] d, input logic [3:0] sel);
        logic e_ack, e_err;
        logic [31:0] e_dat;
        model_access(a, we, d, sel, e_ack, e_err, e_dat);
        @(negedge wb_clk);
        wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
        wb_cti_i = 3'($urandom); wb_bte_i = 2'($urandom);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge wb_clk); #1;
        check({tag, ".ack"}, 32'(wb_ack_o), 32'(e_ack));
        check({tag, ".err"}, 32'(wb_err_o), 32'(e_err));
        if (!we) check({tag, ".dat"}, wb_dat_o, e_dat);
        @(negedge wb_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctl"}, ctl_o, m_ctl);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s.addr%0d", tag, k), addr_o[k], m_addr[k]);
            check($sformatf("%s.chc%0d", tag, k), chc_o[k], m_chc[k]);
        end
    endtask

    task automatic check_irq(input string tag);
        @(posedge wb_clk); #1;
        check(tag, 32'(interrupt), 32'(exp_irq()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] acks;
        for (int k = 0; k < 4; k++) st[k] = '0;
        model_reset();

        // Reset state
        #12;
        check("rst.ack", 32'(wb_ack_o), 32'd0);
        check("rst.err", 32'(wb_err_o), 32'd0);
        check("rst.dat", wb_dat_o, 32'd0);
        check("rst.irq", 32'(interrupt), 32'd0);
        check_outputs("rst");
        @(negedge wb_clk); wb_rst = 1'b1;

        // Full-word write to CH0 ADDRESS
        bus("wr_ch0addr", 8'h04, 1'b1, 32'h12345678, 4'hF);
        check_outputs("after_ch0addr");
        check("rty", 32'(wb_rty_o), 32'd0);

        // Byte-lane write to CH1 CONTROL, then read back
        bus("wr_ch1ctl", 8'h18, 1'b1, 32'hAABBCCDD, 4'h5);
        check("ch1ctl_lanes", chc_o[1], 32'h00BB00DD);
        bus("rd_ch1ctl", 8'h18, 1'b0, '0, 4'hF);

        // Live status read
        st[3] = 32'hDEADBEEF;
        bus("rd_ch3st", 8'h30, 1'b0, '0, 4'hF);

        // Interrupt raise and clear
        bus("wr_ctl", 8'h00, 1'b1, 32'h1, 4'hF);
        bus("wr_ch2ctl", 8'h1C, 1'b1, 32'h2, 4'hF);
        check_irq("irq_pre");
        @(negedge wb_clk); st[2][0] = 1'b1;
        @(posedge wb_clk); #1;
        check("irq_rise", 32'(interrupt), 32'd1);
        bus("clr_ctl", 8'h00, 1'b1, 32'h0, 4'hF);
        check_irq("irq_clear");

        // Unmapped read, unmapped write and status write
        bus("rd_unmapped", 8'h40, 1'b0, '0, 4'hF);
        bus("wr_unmapped", 8'hFC, 1'b1, 32'hFFFFFFFF, 4'hF);
        bus("wr_status", 8'h24, 1'b1, 32'hFFFFFFFF, 4'hF);
        check_outputs("after_bad");

        // Held strobe: responses on alternate cycles
        @(negedge wb_clk);
        wb_adr_i = 8'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk); #1; acks[i] = wb_ack_o;
        end
        check("held_stb", 32'(acks), 32'b0101);
        @(negedge wb_clk); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  a;
            logic        we;
            logic [31:0] d;
            @(negedge wb_clk);
            for (int k = 0; k < 4; k++) st[k] = $urandom;
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12) * 4);
            we = 1'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 3) == 0) d[1:0] = 2'b11;
            bus($sformatf("rnd%0d", i), a, we, d, 4'($urandom));
            check_irq($sformatf("rnd%0d.irq", i));
        end
        check_outputs("rnd_end");

        // Load all RW registers nonzero, then reset mid-cycle
        for (int r = 0; r < 9; r++) bus($sformatf("load%0d", r), 8'(r * 4), 1'b1, 32'hA5000001 + r, 4'hF);
        for (int k = 0; k < 4; k++) st[k] = 32'h1;
        check_irq("load_irq");
        @(negedge wb_clk);
        wb_adr_i = 8'h00; wb_we_i = 1'b1; wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #2 wb_rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.irq", 32'(interrupt), 32'd0);
        @(posedge wb_clk); #1;
        check("async_rst.ack", 32'(wb_ack_o), 32'd0);
        check("async_rst.ctl", ctl_o, 32'd0);
        @(negedge wb_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_rst = 1'b1;
        bus("post_rst_rd", 8'h00, 1'b0, '0, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_daq_slave_regs.md
Name: wb_daq_slave_regs

Overview:
Wishbone B3 classic slave register file for the DAQ subsystem. It holds the global DAQ control word, four per-channel DMA address registers and four per-channel control registers, and drives them as static outputs to the DAQ datapath. It also exposes four read-only channel status inputs and generates a level interrupt. It sits behind the system bus matrix at base 0x2000_0000; only wb_adr_i[7:0] reach the block.

Parameters:
dw, 32, data bus width (only 32 supported)
aw, 8, register address width (byte address)

Ports:
wb_clk  in  1  bus clock
wb_rst  in  1  reset, asynchronous, active-low
wb_adr_i  in  aw  byte address; [1:0] ignored
wb_dat_i  in  dw  write data
wb_sel_i  in  4  byte lane selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type, ignored
wb_bte_i  in  2  burst type, ignored
wb_dat_o  out  dw  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error
wb_rty_o  out  1  retry, tied 0
daq_control_reg  out  32  global control
daq_channel0_address_reg to daq_channel3_address_reg  out  32 each  channel DMA address
daq_channel0_control_reg to daq_channel3_control_reg  out  32 each  channel control
daq_channel0_status_reg to daq_channel3_status_reg  in  32 each  channel status
interrupt  out  1  level interrupt

Behaviour:
- Register map (byte offsets):
  - 0x00 DAQ_CONTROL (RW)
  - 0x04/0x08/0x0C/0x10 CH0..CH3 ADDRESS (RW)
  - 0x14/0x18/0x1C/0x20 CH0..CH3 CONTROL (RW)
  - 0x24/0x28/0x2C/0x30 CH0..CH3 STATUS (RO; reads the live input)
  - All other offsets are unmapped.
- Reset (wb_rst=0, asynchronous): all RW registers 0; wb_ack_o, wb_err_o, wb_dat_o and interrupt all 0.
- Handshake:
  - A request is wb_cyc_i & wb_stb_i & no ack/err currently asserted.
  - wb_ack_o is a registered single-cycle pulse on the clock edge after the request, so latency is 1 cycle.
  - Ack drops the following cycle even if stb is held. A continuously held stb therefore yields an ack every 2nd cycle.
  - cti/bte are ignored, so bursts are handled as repeated classic cycles.
- Writes:
  - Committed on the same edge that asserts ack.
  - Byte lane n is updated only when wb_sel_i[n]=1.
  - The new value is visible on the output port from that edge.
  - Writes to STATUS or unmapped offsets are acked and ignored.
- Reads:
  - wb_dat_o is registered alongside ack and holds the addressed value.
  - Unmapped offsets read 0x0000_0000.
  - wb_dat_o is 0 when ack is low.
- wb_rty_o is constant 0. wb_err_o is 0 unless the optional feature is enabled.
- interrupt:
  - Registered.
  - interrupt = DAQ_CONTROL[0] & OR over k of (CHk_CONTROL[1] & CHk_STATUS[0]).
  - It updates one cycle after any contributing change.
- Simultaneous events: a write to a control register and a status change in the same cycle produce an interrupt computed from the post-write values on the following edge.
- Reset asserted mid-cycle: the transfer is aborted, ack is not issued, and registers clear immediately.

Optional Feature:
WB_DAQ_SLAVE_ERR_EN:
- When defined, the following complete with a wb_err_o pulse instead of wb_ack_o, with the same 1-cycle timing:
  - any access to an unmapped offset;
  - any write to a STATUS offset.
- No register changes on an errored cycle.
- When not defined, wb_err_o is tied 0 and those accesses ack as described above.

Test Plan:
- Write 0x12345678 with sel=0xF to 0x04 -> ack 1 cycle later; daq_channel0_address_reg = 0x12345678; other outputs unchanged at 0.
- Write 0xAABBCCDD with sel=0x5 to 0x18 (CH1 CONTROL, previously 0) -> daq_channel1_control_reg = 0x00BB00DD; read back returns the same value.
- Drive daq_channel3_status_reg = 0xDEADBEEF, read 0x30 -> wb_dat_o = 0xDEADBEEF with ack.
- Write DAQ_CONTROL = 0x1 and CH2 CONTROL = 0x2, then raise daq_channel2_status_reg[0] -> interrupt = 1 one cycle later; clear DAQ_CONTROL[0] -> interrupt = 0.
- Read 0x40 -> ack with data 0; with WB_DAQ_SLAVE_ERR_EN, err=1 and ack=0.
- Load all RW registers with nonzero values, then pulse wb_rst low -> all outputs return to 0 asynchronously.
